// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between fetch (I) and data (D)
// ports, one outstanding transaction. Optional per-transaction timeout: MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_err,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_be,
  input  logic                m_gnt,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                busy
);
  localparam int BE_W = DATA_W/8;
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d, last_q, last_d;
  logic              m_req_q, m_req_d, m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [BE_W-1:0]   m_be_q, m_be_d;
  logic              i_gnt_q, i_gnt_d, d_gnt_q, d_gnt_d;
  logic              i_rvalid_q, i_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic              tmo, drop_q, tmo_fire, pick;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    m_be_d     = m_be_q;
    i_gnt_d    = 1'b0;
    d_gnt_d    = 1'b0;
    i_rvalid_d = 1'b0;
    d_rvalid_d = 1'b0;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    tmo_fire   = 1'b0;
    pick       = OWN_I;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          // Tie goes to whoever did not own the previous transaction.
          pick    = (i_req && (!d_req || last_q == OWN_D)) ? OWN_I : OWN_D;
          owner_d = pick;
          last_d  = pick;
          m_req_d = 1'b1;
          state_d = REQ;
          if (pick == OWN_D) begin
            m_we_d    = d_we;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            m_be_d    = d_be;
            d_gnt_d   = 1'b1;
          end else begin
            m_we_d    = 1'b0;
            m_addr_d  = i_addr;
            m_wdata_d = '0;
            m_be_d    = '1;
            i_gnt_d   = 1'b1;
          end
        end
      end
      REQ: begin
        if (m_gnt && !drop_q) begin
          m_req_d = 1'b0;
          state_d = WAIT;
        end else if (tmo) begin
          tmo_fire = 1'b1;
        end
      end
      WAIT: begin
        if (m_rvalid) begin
          state_d = IDLE;
          if (owner_q == OWN_D) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = m_we_q ? '0 : m_rdata;
          end else begin
            i_rvalid_d = 1'b1;
            i_rdata_d  = m_rdata;
          end
        end else if (tmo) begin
          tmo_fire = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (tmo_fire) begin
      state_d = IDLE;
      m_req_d = 1'b0;
      if (owner_q == OWN_D) begin
        d_rvalid_d = 1'b1;
        d_rdata_d  = '0;
      end else begin
        i_rvalid_d = 1'b1;
        i_rdata_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_I;
      last_q     <= OWN_D;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_be_q     <= '0;
      i_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      m_be_q     <= m_be_d;
      i_gnt_q    <= i_gnt_d;
      d_gnt_q    <= d_gnt_d;
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = 16;
  logic [CNT_W-1:0] cnt_q;
  logic             i_err_q, d_err_q;

  assign tmo = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Counter is held clear in IDLE, so it restarts on every entry to REQ.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      drop_q  <= 1'b0;
      i_err_q <= 1'b0;
      d_err_q <= 1'b0;
    end else begin
      cnt_q   <= (state_q == IDLE) ? '0 : cnt_q + 1'b1;
      if (m_rvalid)
        drop_q <= 1'b0;
      else if (tmo_fire && state_q == WAIT)
        drop_q <= 1'b1;
      i_err_q <= tmo_fire && (owner_q == OWN_I);
      d_err_q <= tmo_fire && (owner_q == OWN_D);
    end
  end

  assign i_err = i_err_q;
  assign d_err = d_err_q;
`else
  // No timeout: the arbiter waits for the memory indefinitely.
  assign tmo    = 1'b0 && (TIMEOUT_CYC > 0);
  assign drop_q = 1'b0;
  assign i_err  = 1'b0;
  assign d_err  = 1'b0;
`endif

  assign i_gnt    = i_gnt_q;
  assign i_rvalid = i_rvalid_q;
  assign i_rdata  = i_rdata_q;
  assign d_gnt    = d_gnt_q;
  assign d_rvalid = d_rvalid_q;
  assign d_rdata  = d_rdata_q;
  assign m_req    = m_req_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign m_be     = m_be_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table plus hand sequences for
// arbitration order, reset mid-transaction and timeout; responses go through a scoreboard.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_gnt, i_rvalid, i_err;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        m_req, m_we, m_gnt, m_rvalid;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;
  logic        busy;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          stall;
    logic [31:0] mrd;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t tbl [5];
  exp_t sb [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic is_d, input logic [31:0] rd, input logic err);
    exp_t e;
    e.is_d = is_d; e.rdata = rd; e.err = err;
    sb.push_back(e);
  endtask

  // Every response pulse must match the oldest outstanding expectation.
  task automatic mon();
    exp_t e;
    if (i_rvalid || d_rvalid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rvalid", {62'd0, i_rvalid, d_rvalid}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("rvalid_port", {62'd0, i_rvalid, d_rvalid}, e.is_d ? 64'd1 : 64'd2);
        chk("rdata", {32'd0, e.is_d ? d_rdata : i_rdata}, {32'd0, e.rdata});
        chk("err", {63'd0, e.is_d ? d_err : i_err}, {63'd0, e.err});
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    mon();
  endtask

  task automatic wait_gnt(output int k);
    k = 0;
    do begin cyc(); k++; end while (!(i_gnt || d_gnt) && k < 8);
  endtask

  // Memory side: stall m_gnt, accept, then respond one cycle later.
  task automatic serve(input int stall, input logic [31:0] rd, input logic [68:0] f);
    for (int s = 0; s < stall; s++) begin
      cyc();
      chk("stall_hold", {59'd0, m_req, m_we, m_be}, {59'd0, 1'b1, f[68], f[3:0]});
      chk("stall_addr_data", {m_addr, m_wdata}, f[67:4]);
    end
    m_gnt = 1'b1;
    cyc();
    m_gnt = 1'b0;
    chk("req_drop_gnt_pulse", {61'd0, m_req, i_gnt, d_gnt}, 64'd0);
    m_rvalid = 1'b1; m_rdata = rd;
    cyc();
    m_rvalid = 1'b0; m_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic run_vec(input vec_t v);
    int k;
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_be = v.be;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    wait_gnt(k);
    chk("gnt_latency", 64'(k), 64'd1);
    chk("gnt", {62'd0, i_gnt, d_gnt}, v.is_d ? 64'd1 : 64'd2);
    chk("m_ctrl", {57'd0, m_req, m_we, busy, m_be}, {57'd0, 1'b1, v.we, 1'b1, v.exp_be});
    chk("m_addr_data", {m_addr, m_wdata}, {v.addr, v.exp_wdata});
    i_req = 1'b0; d_req = 1'b0;
    push_exp(v.is_d, v.exp_rdata, 1'b0);
    serve(v.stall, v.mrd, {v.we, v.addr, v.exp_wdata, v.exp_be});
    chk("rv_on_time", {61'd0, i_rvalid, d_rvalid, busy}, v.is_d ? 64'd2 : 64'd4);
    cyc();
    chk("rv_pulse", {62'd0, i_rvalid, d_rvalid}, 64'd0);
    chk("sb_drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int  k;
    logic seen;
    rst = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    d_be = 0; m_gnt = 0; m_rvalid = 0; m_rdata = 0;

    //         is_d we  addr          wdata         be    stall mrd           exp_be exp_wdata exp_rdata
    tbl[0] = '{1'b0, 0, 32'h0040_0000, 32'h0,        4'h0, 0, 32'h00A0_0093, 4'hF, 32'h0,     32'h00A0_0093};
    tbl[1] = '{1'b1, 1, 32'h1001_0004, 32'hCAFE_F00D, 4'h3, 3, 32'h1234_5678, 4'h3, 32'hCAFE_F00D, 32'h0};
    tbl[2] = '{1'b1, 0, 32'h1001_0008, 32'h0,        4'hF, 1, 32'h0BAD_F00D, 4'hF, 32'h0,     32'h0BAD_F00D};
    tbl[3] = '{1'b0, 0, 32'h0040_0004, 32'h0,        4'h0, 2, 32'hFFFF_FFFF, 4'hF, 32'h0,     32'hFFFF_FFFF};
    tbl[4] = '{1'b1, 0, 32'h1001_000C, 32'h0,        4'h4, 0, 32'h5A5A_5A5A, 4'h4, 32'h0,     32'h5A5A_5A5A};

    repeat (3) cyc();
    rst = 1'b0;
    chk("rst_ctrl", {51'd0, i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, m_req, m_we, busy, m_be}, 64'd0);
    chk("rst_rdata", {i_rdata, d_rdata}, 64'd0);
    chk("rst_mem", {m_addr, m_wdata}, 64'd0);

    // Continuous contention straight after reset: I, D, I, D.
    i_req = 1'b1; i_addr = 32'h0040_0100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0100; d_wdata = 32'h0; d_be = 4'hF;
    for (int g = 0; g < 4; g++) begin
      wait_gnt(k);
      chk("alt_gnt", {62'd0, i_gnt, d_gnt}, (g % 2 == 0) ? 64'd2 : 64'd1);
      chk("alt_addr_be", {28'd0, m_addr, m_be},
          {28'd0, (g % 2 == 0) ? 32'h0040_0100 : 32'h1001_0100, 4'hF});
      push_exp(g % 2 == 1, 32'h0000_1000 + 32'(g), 1'b0);
      serve(0, 32'h0000_1000 + 32'(g), {1'b0, (g % 2 == 0) ? 32'h0040_0100 : 32'h1001_0100, 32'h0, 4'hF});
      if (g == 3) begin i_req = 1'b0; d_req = 1'b0; end
    end
    cyc();
    chk("alt_drain", {63'd0, busy}, 64'd0);

    for (int i = 0; i < 5; i++) run_vec(tbl[i]);

    // Reset while waiting for the memory response; the late response is dropped.
    i_req = 1'b1; i_addr = 32'h0040_0200;
    wait_gnt(k);
    i_req = 1'b0;
    m_gnt = 1'b1; cyc(); m_gnt = 1'b0;
    chk("pre_rst_wait", {62'd0, busy, m_req}, 64'd2);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("mid_rst_ctrl", {51'd0, i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, m_req, m_we, busy, m_be}, 64'd0);
    chk("mid_rst_data", {i_rdata, d_rdata}, 64'd0);
    m_rvalid = 1'b1; m_rdata = 32'h1111_2222; cyc(); m_rvalid = 1'b0;
    cyc();
    chk("late_rvalid_ignored", {61'd0, i_rvalid, d_rvalid, busy}, 64'd0);
    run_vec(tbl[0]);

    // Data read the memory accepts but never answers.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1002_0000; d_be = 4'hF;
    wait_gnt(k);
    d_req = 1'b0;
    chk("tmo_gnt", {62'd0, i_gnt, d_gnt}, 64'd1);
`ifdef MEM_ARB_TIMEOUT_EN
    push_exp(1'b1, 32'h0, 1'b1);
    m_gnt = 1'b1; cyc(); m_gnt = 1'b0;
    for (int s = 0; s < 6; s++) begin
      cyc();
      chk("tmo_pending", {63'd0, d_rvalid}, 64'd0);
    end
    cyc();
    chk("tmo_resp", {61'd0, d_rvalid, d_err, busy}, 64'd6);
    m_rvalid = 1'b1; m_rdata = 32'h7777_7777; cyc(); m_rvalid = 1'b0;
    chk("stale_dropped", {62'd0, i_rvalid, d_rvalid}, 64'd0);
    cyc();
    chk("stale_dropped2", {62'd0, i_rvalid, d_rvalid}, 64'd0);
    run_vec(tbl[2]);
`else
    m_gnt = 1'b1; cyc(); m_gnt = 1'b0;
    seen = 1'b0;
    for (int s = 0; s < 40; s++) begin
      cyc();
      seen = seen | d_err | d_rvalid | i_err | ~busy;
    end
    chk("no_timeout", {63'd0, seen}, 64'd0);
    chk("still_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1; cyc(); rst = 1'b0;
    run_vec(tbl[3]);
`endif

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified single-port memory between the instruction-fetch port (I, read-only) and the data port (D, read/write) of the multicycle core.
- Uses round-robin arbitration and holds one outstanding transaction at a time.
- Sits between the core and the memory model, so the core can run against a single variable-latency memory instead of separate ideal instruction and data memories.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width. Byte-enable width is DATA_W/8.
- TIMEOUT_CYC, 64, cycle limit per transaction. Used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- i_req  in  1  fetch request; held with i_addr until i_gnt
- i_addr  in  ADDR_W  fetch address
- i_gnt  out  1  one-cycle pulse: fetch request captured
- i_rvalid  out  1  one-cycle pulse: fetch data valid
- i_rdata  out  DATA_W  fetch data
- i_err  out  1  fetch timed out; qualified by i_rvalid
- d_req  in  1  data request; held with all d_* fields until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_be  in  DATA_W/8  byte enables
- d_gnt  out  1  one-cycle pulse: data request captured
- d_rvalid  out  1  one-cycle pulse: read data valid or write acknowledged
- d_rdata  out  DATA_W  read data; 0 for writes
- d_err  out  1  data transaction timed out; qualified by d_rvalid
- m_req  out  1  memory request
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_be  out  DATA_W/8  memory byte enables; all-ones for fetches
- m_gnt  in  1  memory accepted request (sampled while m_req=1)
- m_rvalid  in  1  memory response or write ack; never in the same cycle as m_gnt
- m_rdata  in  DATA_W  memory read data
- busy  out  1  state != IDLE

Behaviour:
- Reset rst, synchronous, active-high; clock clk.
- Reset values:
  - state = IDLE; last_owner = D, so I wins the first tie.
  - All outputs 0; captured registers 0.
- Reset mid-transaction abandons it: m_req drops the cycle after reset is sampled, and no response is delivered.
- States: IDLE, REQ, WAIT.
- IDLE:
  - If any req is high, pick a winner: the only requester, or on a tie the one that is not last_owner.
  - Capture the winner's addr/we/wdata/be into m_* registers, set owner and last_owner.
  - Next cycle: x_gnt=1 for exactly one cycle, m_req=1, state=REQ.
  - m_rvalid in IDLE is ignored.
- REQ:
  - m_req and m_* fields stay stable.
  - On m_gnt=1: next cycle m_req=0, state=WAIT.
- WAIT:
  - On m_rvalid=1: next cycle the owner's x_rvalid=1 for one cycle and x_rdata=m_rdata (0 if write); state=IDLE.
- Every registered output is driven from flops; there are no combinational paths from requester or memory inputs to outputs.
- Timing: request sampled at t gives gnt at t+1.
  - With m_gnt at t+1 and m_rvalid at t+2, rvalid appears at t+3.
  - IDLE at t+3 may sample a new request, overlapping the rvalid pulse.
- A requester must drop req the cycle after gnt, unless it wants another transaction. A req still high in IDLE is treated as a new request.
- Requests arriving while busy wait; they are never lost, only delayed.
- i_rdata/d_rdata hold their last value between pulses; the non-owner's rvalid stays 0.
- Round-robin guarantees that, under continuous contention, grants strictly alternate I, D, I, D.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter clears on entry to REQ and counts every cycle in REQ and WAIT.
  - When it reaches TIMEOUT_CYC without m_gnt (in REQ) or m_rvalid (in WAIT), the next cycle gives m_req=0, owner x_rvalid=1, x_err=1, x_rdata=0, state=IDLE.
  - On a timeout in WAIT, a drop_pending flag is set; the next m_rvalid is discarded and clears it. New transactions may issue while drop_pending is set, but the REQ->WAIT transition is held until it clears.
- Undefined: no counter or flag is instantiated; i_err and d_err are tied 0; the arbiter waits indefinitely.

Test Plan:
- Reset, then i_req=1, i_addr=0x00400000; memory gnt immediately and rvalid 1 cycle later with rdata=0x00A00093 -> i_gnt at t+1, m_addr=0x00400000, i_rvalid at t+3 with i_rdata=0x00A00093, busy low at t+3.
- i_req and d_req both high at the same cycle after reset -> I granted first, then D, then I, alternating; m_be=4'hF on fetches.
- d_we=1, d_addr=0x10010004, d_wdata=0xCAFEF00D, d_be=4'b0011 -> m_we=1 with identical fields held through 3 stall cycles of m_gnt=0; d_rvalid=1, d_rdata=0.
- rst asserted in WAIT, then a late m_rvalid arrives -> no x_rvalid pulse; all outputs 0; next i_req served normally.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYC=8, memory never returns rvalid for a D read -> d_rvalid=1, d_err=1, d_rdata=0 after 8 cycles in REQ+WAIT; a later stale m_rvalid is discarded.
- Without the macro, same stimulus -> busy stays high indefinitely and d_err is never asserted.
